// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU op sequencer: opcodes, FSM state encodings
// and bit positions within the {N,Z,V,C} flag nibble.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_RSV = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_C = 0;

    // Shifts only ever operate on the low word.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_sticky.sv
// Sticky {V,C} accumulator. Each response handshake ORs in its flags; a clear
// coinciding with a handshake leaves only the new flags.
module alu_seq_sticky (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hs_i,
    input  logic [1:0] vc_i,
    input  logic       clr_i,
    output logic [1:0] sticky_vc_o
);

    logic [1:0] sticky_q, sticky_d;

    // Next sticky value: handshake has priority over clear.
    always_comb begin
        sticky_d = sticky_q;
        if (hs_i && clr_i) begin
            sticky_d = vc_i;
        end else if (hs_i) begin
            sticky_d = sticky_q | vc_i;
        end else if (clr_i) begin
            sticky_d = '0;
        end
    end

    // Sticky register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_vc_o = sticky_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request through an external combinational ALU in one pass
// (narrow) or two passes low/high word (wide), then holds the response.
// Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN adds sticky {V,C} flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic                req_cin,
    input  logic                req_wide,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [3:0]          alu_sel,
    output logic                alu_cin,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_n,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_c,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic [3:0]          rsp_flags
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic                sticky_clr,
    output logic [1:0]          sticky_vc
`endif
);

    logic [1:0]          state_q, state_d;
    logic [2:0]          op_q;
    logic [2*DATA_W-1:0] a_q, b_q;
    logic                cin_q;
    logic                wide_q;
    logic [DATA_W-1:0]   lo_q;
    logic                zlo_q;
    logic                chi_q;
    logic [2*DATA_W-1:0] rsp_data_q;
    logic [3:0]          rsp_flags_q;
    logic [3:0]          lo_flags, hi_flags;
    logic                accept;

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Next-state logic: IDLE -> LO -> (HI) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_LO;
            ST_LO:   state_d = wide_q ? ST_HI : ST_DONE;
            ST_HI:   state_d = ST_DONE;
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Flag nibbles for the low pass and the combined wide result.
    always_comb begin
        lo_flags         = '0;
        lo_flags[FLAG_N] = alu_n;
        lo_flags[FLAG_Z] = alu_z;
        lo_flags[FLAG_V] = alu_v;
        lo_flags[FLAG_C] = alu_c;
        hi_flags         = lo_flags;
        hi_flags[FLAG_Z] = alu_z & zlo_q;
    end

    // State, request capture and per-pass result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            wide_q      <= 1'b0;
            lo_q        <= '0;
            zlo_q       <= 1'b0;
            chi_q       <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= req_op;
                a_q    <= req_a;
                b_q    <= req_b;
                cin_q  <= req_cin;
                wide_q <= req_wide && !is_shift(req_op);
            end
            if (state_q == ST_LO) begin
                lo_q  <= alu_out;
                zlo_q <= alu_z;
                chi_q <= (op_q == OP_ADD) && alu_c;
                if (!wide_q) begin
                    rsp_data_q  <= {{DATA_W{1'b0}}, alu_out};
                    rsp_flags_q <= lo_flags;
                end
            end
            if (state_q == ST_HI) begin
                rsp_data_q  <= {alu_out, lo_q};
                rsp_flags_q <= hi_flags;
            end
        end
    end

    // ALU operand steering; idle/done cycles present all-zero to the ALU.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        alu_cin = 1'b0;
        case (state_q)
            ST_LO: begin
                alu_a   = a_q[DATA_W-1:0];
                alu_b   = b_q[DATA_W-1:0];
                alu_sel = {1'b0, op_q};
                alu_cin = cin_q;
            end
            ST_HI: begin
                alu_a   = a_q[2*DATA_W-1:DATA_W];
                alu_b   = b_q[2*DATA_W-1:DATA_W];
                alu_sel = {1'b0, op_q};
                alu_cin = chi_q;
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    alu_seq_sticky u_sticky (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs_i        (rsp_valid && rsp_ready),
        .vc_i        ({rsp_flags_q[FLAG_V], rsp_flags_q[FLAG_C]}),
        .clr_i       (sticky_clr),
        .sticky_vc_o (sticky_vc)
    );
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU attached.
// Build with ALU_SEQ_STICKY_FLAGS_EN to include the sticky-flag checks.
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [2*W-1:0] req_a, req_b;
    logic          req_cin, req_wide;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [3:0]    alu_sel;
    logic          alu_cin, alu_n, alu_z, alu_v, alu_c;
    logic          rsp_valid, rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic [3:0]    rsp_flags;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic          sticky_clr;
    logic [1:0]    sticky_vc;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_wide  (req_wide),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_cin   (alu_cin),
        .alu_out   (alu_out),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .alu_c     (alu_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags)
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        ,
        .sticky_clr(sticky_clr),
        .sticky_vc (sticky_vc)
`endif
    );

    // External ALU: anything not listed behaves as add.
    always_comb begin
        logic [W:0] sum;
        sum     = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        alu_out = sum[W-1:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_sel)
            4'b0001: alu_out = alu_a & alu_b;
            4'b0010: alu_out = alu_a | alu_b;
            4'b0011: alu_out = alu_a ^ alu_b;
            4'b0100: alu_out = ~(alu_a | alu_b);
            4'b0101: alu_out = alu_a << alu_b[4:0];
            4'b0110: alu_out = alu_a >> alu_b[4:0];
            default: begin
                alu_c = sum[W];
                alu_v = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
            end
        endcase
        alu_n = alu_out[W-1];
        alu_z = (alu_out == '0);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One request end to end; hold>0 keeps rsp_ready low that many cycles
    // while offering a competing request that must be ignored.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic wide,
                          input logic [63:0] exp_data, input logic [3:0] exp_flags,
                          input int exp_lat, input logic exp_hi_cin, input int hold);
        int lat;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_cin = cin; req_wide = wide;
        req_valid = 1'b1;
        check_eq({tag, ".ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        check_eq({tag, ".lo_sel"}, 64'(alu_sel), {60'd0, 1'b0, op});
        check_eq({tag, ".lo_a"}, 64'(alu_a), {32'd0, a[31:0]});
        check_eq({tag, ".lo_cin"}, 64'(alu_cin), 64'(cin));
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 2 && exp_lat == 3) begin
                check_eq({tag, ".hi_a"}, 64'(alu_a), {32'd0, a[63:32]});
                check_eq({tag, ".hi_cin"}, 64'(alu_cin), 64'(exp_hi_cin));
            end
        end
        check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".data"}, rsp_data, exp_data);
        check_eq({tag, ".flags"}, 64'(rsp_flags), 64'(exp_flags));
        check_eq({tag, ".done_alu"}, {alu_a, 28'd0, alu_sel}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_op = 3'b011; req_a = '1; req_b = 64'h1234; req_wide = 1'b0;
            @(negedge clk);
            check_eq({tag, ".bp_valid"}, 64'(rsp_valid), 64'd1);
            check_eq({tag, ".bp_ready"}, 64'(req_ready), 64'd0);
            check_eq({tag, ".bp_data"}, rsp_data, exp_data);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, ".post_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, ".post_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, ".post_sel"}, 64'(alu_sel), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_cin = 1'b0; req_wide = 1'b0; rsp_ready = 1'b0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst.valid", 64'(rsp_valid), 64'd0);
        check_eq("rst.data", rsp_data, 64'd0);
        check_eq("rst.flags", 64'(rsp_flags), 64'd0);
        check_eq("rst.alu", {alu_a, alu_b}, 64'd0);
        check_eq("rst.alu_ctl", {59'd0, alu_sel, alu_cin}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst.ready", 64'(req_ready), 64'd1);

        //      tag    op      a                       b                       cin   wide  data                    flags    lat hicin hold
        run_op("wadd", 3'b000, 64'h00000000_FFFFFFFF, 64'h1,                  1'b0, 1'b1, 64'h00000001_00000000, 4'b0000, 3, 1'b1, 0);
        run_op("nxor", 3'b011, 64'h0000_0000_F0F0F0F0, 64'hFFFFFFFF,          1'b0, 1'b0, 64'h00000000_0F0F0F0F, 4'b0000, 2, 1'b0, 0);
        run_op("wz0",  3'b000, 64'h0,                  64'h0,                  1'b0, 1'b1, 64'h0,                  4'b0100, 3, 1'b0, 0);
        run_op("wz1",  3'b000, 64'h1,                  64'h0,                  1'b0, 1'b1, 64'h1,                  4'b0000, 3, 1'b0, 0);
        run_op("nand", 3'b001, 64'hFFFF0000_12345678, 64'hFFFFFFFF_0000FFFF, 1'b0, 1'b0, 64'h00000000_00005678, 4'b0000, 2, 1'b0, 0);
        run_op("shl",  3'b101, 64'hAAAA5555_00000001, 64'h4,                  1'b0, 1'b1, 64'h10,                 4'b0000, 2, 1'b0, 0);
        run_op("shr",  3'b110, 64'h00000000_80000000, 64'd31,                 1'b0, 1'b1, 64'h1,                  4'b0000, 2, 1'b0, 0);
        run_op("wor",  3'b010, 64'h80000000_00000000, 64'h0,                  1'b1, 1'b1, 64'h80000000_00000000, 4'b1000, 3, 1'b0, 0);
        run_op("op7",  3'b111, 64'h5,                  64'h3,                  1'b1, 1'b0, 64'h9,                  4'b0000, 2, 1'b0, 0);
        run_op("bp",   3'b100, 64'h0,                  64'h0,                  1'b0, 1'b0, 64'h00000000_FFFFFFFF, 4'b1000, 2, 1'b0, 5);
        run_op("wovf", 3'b000, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, 1'b0, 1'b1, 64'h80000000_00000000, 4'b1010, 3, 1'b0, 0);

        // Reset pulse while the high pass is in flight.
        @(negedge clk);
        req_op = 3'b000; req_a = 64'h00000000_FFFFFFFF; req_b = 64'h1; req_cin = 1'b0; req_wide = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("mid.in_hi", 64'(alu_cin), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid.valid", 64'(rsp_valid), 64'd0);
        check_eq("mid.data", rsp_data, 64'd0);
        check_eq("mid.flags", 64'(rsp_flags), 64'd0);
        check_eq("mid.alu", {alu_a, 27'd0, alu_sel, alu_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid.ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mid.no_rsp", 64'(rsp_valid), 64'd0);
        end
        run_op("wcar", 3'b000, 64'hFFFFFFFF_FFFFFFFF, 64'h1,                  1'b0, 1'b1, 64'h0,                  4'b0101, 3, 1'b1, 0);

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        check_eq("stk.clr0", 64'(sticky_vc), 64'd0);
        run_op("stk1", 3'b000, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b1, 64'h0, 4'b0101, 3, 1'b1, 0);
        run_op("stk2", 3'b000, 64'h1,                  64'h0, 1'b0, 1'b1, 64'h1, 4'b0000, 3, 1'b0, 0);
        check_eq("stk.vc", 64'(sticky_vc), 64'd1);
        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        check_eq("stk.clr1", 64'(sticky_vc), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit in case the design never responds.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, ALU word width; the wide result is 2*DATA_W.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  op request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_op  in  3  ALU opcode: 000 add, 001 and, 010 or, 011 xor, 100 nor, 101 shl, 110 shr.
REQ-007 SHALL have ports req_a, req_b  in  2*DATA_W each  operands.
REQ-008 SHALL have ports req_cin  in  1  add carry-in, and req_wide  in  1  two-pass op.
REQ-009 SHALL have ports alu_a, alu_b  out  DATA_W each; alu_sel  out  4; alu_cin  out  1; all drive the combinational ALU.
REQ-010 SHALL have ports alu_out  in  DATA_W, and alu_n, alu_z, alu_v, alu_c  in  1 each, sampled from the ALU.
REQ-011 SHALL have ports rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  2*DATA_W; rsp_flags  out  4, ordered {N,Z,V,C}.

Function
REQ-012 SHALL implement FSM IDLE->LO->(HI if wide)->DONE->IDLE.
REQ-013 SHALL assert req_ready only in IDLE; on req_valid&&req_ready, SHALL capture all req_* and enter LO.
REQ-014 In LO, SHALL drive low operand words, alu_sel={0,op}, alu_cin=req_cin, and register alu_out plus flags at the cycle end.
REQ-015 In HI, SHALL drive high words, with alu_cin=C captured in LO for add and 0 otherwise; SHALL register the high result.
REQ-016 Shift ops SHALL be treated as narrow regardless of req_wide.
REQ-017 Narrow result SHALL be {DATA_W zeros, low}; flags SHALL be the LO-pass flags.
REQ-018 Wide flags: N, V and C SHALL come from HI; Z SHALL be Z_lo AND Z_hi.
REQ-019 rsp_valid SHALL be high only in DONE; rsp_data and rsp_flags SHALL hold stable until rsp_ready, then the FSM SHALL return to IDLE.
REQ-020 Latency from accept SHALL be 2 cycles narrow and 3 cycles wide; max throughput SHALL be one op per 3 (narrow) or 4 (wide) cycles.
REQ-021 Opcode 111 SHALL be passed through unchanged; the ALU default yields add.
REQ-022 alu_* outputs SHALL be 0 in IDLE and DONE.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, with rsp_valid=0, rsp_data=0, rsp_flags=0, alu_*=0, and req_ready=1 after release.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight op without emitting a response.

Configuration
REQ-025 With ALU_SEQ_STICKY_FLAGS_EN defined, SHALL add input sticky_clr (1) and output sticky_vc (2).
REQ-026 With the macro defined, sticky_vc SHALL OR in {V,C} of each response at its rsp handshake.
REQ-027 With the macro defined, sticky_vc SHALL clear on sticky_clr; a simultaneous handshake SHALL win, loading only the new flags. Reset value SHALL be 0.
REQ-028 Without the macro, the sticky ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Opcode constants, FSM state encodings and flag bit indices SHALL live in shared package alu_seq_pkg.
REQ-030 The ALU SHALL stay external; the sticky register SHALL be sub-module alu_seq_sticky, instantiated only under the macro.

Verification
REQ-031 Wide add: a=0x00000000_FFFFFFFF, b=1, cin=0 -> LO alu_c=1, HI alu_cin=1; rsp_data=0x00000001_00000000, flags N0 Z0 V0 C0, rsp_valid 3 cycles after accept.
REQ-032 Narrow xor: a=0xF0F0F0F0, b=0xFFFFFFFF -> rsp_data=0x00000000_0F0F0F0F, flags N0 Z0, rsp_valid 2 cycles after accept.
REQ-033 Wide add zero: a=0, b=0 -> Z=1. Also: a=0x00000000_00000001, b=0 -> Z=0, which checks the Z_lo AND Z_hi rule.
REQ-034 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_data stable, req_ready=0, a second req_valid is ignored.
REQ-035 Reset mid-op: pulse rst_n low during HI -> no rsp_valid, outputs 0, next request completes normally.
REQ-036 Sticky (macro on): two wide adds with C=1 then C=0 -> sticky_vc=01; sticky_clr -> 00.
